// File: rtl/ssd1306_pkg.sv
// ssd1306_pkg: shared types, opcodes and panel geometry for the SSD1306 emulator
package ssd1306_pkg;
  localparam int COLS_DEF = 128;
  localparam int PAGES_DEF = 8;
  typedef enum logic [1:0] {HORIZ = 2'd0, VERT = 2'd1, PAGE = 2'd2} addr_mode_t;
  typedef enum logic [1:0] {IDLE, ARG1, ARG2} cmd_state_t;
  localparam logic [7:0] OP_MODE     = 8'h20;
  localparam logic [7:0] OP_COLS     = 8'h21;
  localparam logic [7:0] OP_PAGES    = 8'h22;
  localparam logic [7:0] OP_CONTRAST = 8'h81;
  localparam logic [7:0] OP_DISP_OFF = 8'hAE;
  localparam logic [7:0] OP_DISP_ON  = 8'hAF;
  localparam logic [7:0] OP_NORMAL   = 8'hA6;
  localparam logic [7:0] OP_INVERT   = 8'hA7;
  function automatic logic takes_one_arg(input logic [7:0] op);
    return op inside {OP_MODE, OP_CONTRAST, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D};
  endfunction
endpackage

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: synchronises the 4-wire SPI pins and assembles mode-0 bytes, MSB first
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       greset,
  input  logic       sck,
  input  logic       mosi,
  input  logic       cs_n,
  input  logic       dc,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       is_data,
  output logic       cs_idle
);
  logic [SYNC_STAGES-1:0][3:0] sync;
  logic       sck_q;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic       s_sck, s_mosi, s_dc;
  assign {s_sck, s_mosi, cs_idle, s_dc} = sync[SYNC_STAGES-1];
  always_ff @(posedge clk or posedge greset)
    if (greset) begin
      sync       <= '0;
      sck_q      <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      is_data    <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], {sck, mosi, cs_n, dc}};
      sck_q      <= s_sck;
      byte_valid <= 1'b0;
      if (cs_idle) bit_cnt <= '0;
      else if (s_sck && !sck_q) begin
        shreg   <= {shreg[5:0], s_mosi};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          rx_byte    <= {shreg, s_mosi};
          is_data    <= s_dc;
        end
      end
    end
endmodule

// File: rtl/ssd1306_cmd_ctrl.sv
// ssd1306_cmd_ctrl: SSD1306 command interpreter placing SPI data bytes into the framebuffer
module ssd1306_cmd_ctrl
  import ssd1306_pkg::*;
#(
  parameter int COLS        = COLS_DEF,
  parameter int PAGES       = PAGES_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       greset,
  input  logic       sck,
  input  logic       mosi,
  input  logic       cs_n,
  input  logic       dc,
  output logic       fb_we,
  output logic [9:0] fb_addr,
  output logic [7:0] fb_wdata,
  output logic       display_on,
  output logic       invert,
  output logic [7:0] contrast
);
  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);
  logic          byte_valid, is_data, cs_idle;
  logic [7:0]    rx_byte, opcode;
  logic [CW-1:0] arg1;
  addr_mode_t    mode;
  cmd_state_t    state;
  logic [CW-1:0] col_ptr, col_start, col_end, col_inc, col_step, nxt_col;
  logic [PW-1:0] page_ptr, page_start, page_end, page_inc, page_step, nxt_page;
  logic          col_wrap, page_wrap, page_mode;
  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk(clk), .greset(greset), .sck(sck), .mosi(mosi), .cs_n(cs_n), .dc(dc),
    .byte_valid(byte_valid), .rx_byte(rx_byte), .is_data(is_data), .cs_idle(cs_idle)
  );
  // Ranges with start>end are legal, so wrapping is by equality with end, counting mod COLS/PAGES
  always_comb begin
    col_wrap  = col_ptr == col_end;
    page_wrap = page_ptr == page_end;
    col_inc   = (col_ptr == CW'(COLS - 1)) ? '0 : col_ptr + 1'b1;
    page_inc  = (page_ptr == PW'(PAGES - 1)) ? '0 : page_ptr + 1'b1;
    col_step  = col_wrap ? col_start : col_inc;
    page_step = page_wrap ? page_start : page_inc;
    nxt_col   = (mode == VERT) ? (page_wrap ? col_step : col_ptr) : col_step;
    nxt_page  = (mode == HORIZ) ? (col_wrap ? page_step : page_ptr) :
                (mode == VERT) ? page_step : page_ptr;
    page_mode = mode == PAGE;
  end
  always_ff @(posedge clk or posedge greset)
    if (greset) begin
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_wdata   <= '0;
      display_on <= 1'b0;
      invert     <= 1'b0;
      contrast   <= 8'h7F;
      mode       <= PAGE;
      state      <= IDLE;
      opcode     <= '0;
      arg1       <= '0;
      col_start  <= '0;
      col_end    <= CW'(COLS - 1);
      page_start <= '0;
      page_end   <= PW'(PAGES - 1);
      col_ptr    <= '0;
      page_ptr   <= '0;
    end else begin
      fb_we <= 1'b0;
      if (byte_valid && is_data) begin
        fb_we    <= 1'b1;
        fb_addr  <= 10'(page_ptr) * 10'(COLS) + 10'(col_ptr);
        fb_wdata <= rx_byte;
        col_ptr  <= nxt_col;
        page_ptr <= nxt_page;
        state    <= IDLE;
      end else if (byte_valid) begin
        case (state)
          IDLE: begin
            opcode <= rx_byte;
            if (rx_byte == OP_COLS || rx_byte == OP_PAGES || takes_one_arg(rx_byte)) state <= ARG1;
            if (page_mode && rx_byte[7:4] == 4'h0) col_ptr[3:0] <= rx_byte[3:0];
            if (page_mode && rx_byte[7:3] == 5'b00010) col_ptr[CW-1:4] <= rx_byte[CW-5:0];
            if (page_mode && rx_byte[7:3] == 5'b10110) page_ptr <= rx_byte[PW-1:0];
            if (rx_byte == OP_DISP_OFF || rx_byte == OP_DISP_ON) display_on <= rx_byte[0];
            if (rx_byte == OP_NORMAL || rx_byte == OP_INVERT) invert <= rx_byte[0];
          end
          ARG1: begin
            arg1  <= rx_byte[CW-1:0];
            state <= (opcode == OP_COLS || opcode == OP_PAGES) ? ARG2 : IDLE;
            if (opcode == OP_MODE && rx_byte[1:0] != 2'd3) mode <= addr_mode_t'(rx_byte[1:0]);
            if (opcode == OP_CONTRAST) contrast <= rx_byte;
          end
          default: begin
            state <= IDLE;
            if (opcode == OP_COLS) begin
              col_start <= arg1;
              col_end   <= rx_byte[CW-1:0];
              col_ptr   <= arg1;
            end
            if (opcode == OP_PAGES) begin
              page_start <= arg1[PW-1:0];
              page_end   <= rx_byte[PW-1:0];
              page_ptr   <= arg1[PW-1:0];
            end
          end
        endcase
      end else if (cs_idle) state <= IDLE;
    end
endmodule

// File: tb/tb_ssd1306_cmd_ctrl.sv
// tb_ssd1306_cmd_ctrl: directed SPI command/data stimulus with a framebuffer-write scoreboard
`timescale 1ns/1ps
module tb_ssd1306_cmd_ctrl;
  localparam int SYNC = 2;
  logic clk = 1'b0, greset, sck, mosi, cs_n, dc;
  logic fb_we, display_on, invert;
  logic [9:0] fb_addr;
  logic [7:0] fb_wdata, contrast;
  int total = 0, bad = 0, lat;
  logic [17:0] sb[$];
  always #5 clk = ~clk;
  ssd1306_cmd_ctrl #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .greset(greset), .sck(sck), .mosi(mosi), .cs_n(cs_n), .dc(dc),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .display_on(display_on), .invert(invert), .contrast(contrast)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (fb_we) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr %0d data %0h, none expected", fb_addr, fb_wdata);
      end else begin
        logic [17:0] e;
        e = sb.pop_front();
        chk("fb_addr", 32'(fb_addr), 32'(e[17:8]));
        chk("fb_wdata", 32'(fb_wdata), 32'(e[7:0]));
      end
    end
  task automatic send_bits(input logic [7:0] b, input logic d, input int n, input bit meas);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk);
      mosi = b[i];
      dc = d;
      repeat (4) @(negedge clk);
      sck = 1'b1;
      if (meas && i == 0) begin
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
          @(posedge clk);
          #1;
          if (fb_we && lat == 0) lat = k;
        end
        chk("latency", 32'(lat), 32'(SYNC + 2));
      end else repeat (4) @(negedge clk);
      @(negedge clk);
      sck = 1'b0;
    end
  endtask
  task automatic cmd(input logic [7:0] b);
    send_bits(b, 1'b0, 8, 1'b0);
  endtask
  task automatic dat(input logic [7:0] b, input logic [9:0] a);
    sb.push_back({a, b});
    send_bits(b, 1'b1, 8, 1'b0);
  endtask
  task automatic check_reset_vals();
    chk("rst_fb_we", 32'(fb_we), 0);
    chk("rst_fb_addr", 32'(fb_addr), 0);
    chk("rst_fb_wdata", 32'(fb_wdata), 0);
    chk("rst_display_on", 32'(display_on), 0);
    chk("rst_invert", 32'(invert), 0);
    chk("rst_contrast", 32'(contrast), 32'h7F);
  endtask
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    greset = 1'b1; sck = 1'b0; mosi = 1'b0; cs_n = 1'b1; dc = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    greset = 1'b0;
    repeat (3) @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    cmd(8'hAF);
    chk("display_on", 32'(display_on), 1);
    sb.push_back({10'd0, 8'h55});
    send_bits(8'h55, 1'b1, 8, 1'b1);
    dat(8'h66, 10'd1);
    cmd(8'h20); cmd(8'h00);
    cmd(8'h21); cmd(8'd126); cmd(8'd127);
    cmd(8'h22); cmd(8'd6); cmd(8'd7);
    dat(8'h01, 10'd894); dat(8'h02, 10'd895); dat(8'h03, 10'd1022);
    dat(8'h04, 10'd1023); dat(8'h05, 10'd894);
    cmd(8'h20); cmd(8'h01);
    cmd(8'h21); cmd(8'd0); cmd(8'd1);
    cmd(8'h22); cmd(8'd0); cmd(8'd1);
    dat(8'h11, 10'd0); dat(8'h12, 10'd128); dat(8'h13, 10'd1);
    dat(8'h14, 10'd129); dat(8'h15, 10'd0);
    cmd(8'h20); cmd(8'h02);
    cmd(8'h21); cmd(8'd0); cmd(8'd127);
    cmd(8'h22); cmd(8'd0); cmd(8'd7);
    cmd(8'hB3); cmd(8'h05); cmd(8'h17);
    dat(8'h21, 10'd501); dat(8'h22, 10'd502);
    cmd(8'h0F);
    dat(8'h23, 10'd511); dat(8'h24, 10'd384);
    cmd(8'h81);
    send_bits(8'h3C, 1'b0, 4, 1'b0);
    @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    cmd(8'hA7);
    chk("abort_contrast", 32'(contrast), 32'h7F);
    chk("abort_invert", 32'(invert), 1);
    chk("abort_display_on", 32'(display_on), 1);
    cmd(8'h21); cmd(8'h10);
    dat(8'hAA, 10'd385);
    cmd(8'hA6);
    chk("idle_after_data", 32'(invert), 0);
    dat(8'hBB, 10'd386);
    cmd(8'h81); cmd(8'h33);
    chk("contrast", 32'(contrast), 32'h33);
    send_bits(8'hF0, 1'b1, 4, 1'b0);
    #3;
    greset = 1'b1;
    #1;
    check_reset_vals();
    sck = 1'b0; cs_n = 1'b1;
    repeat (3) @(negedge clk);
    greset = 1'b0;
    repeat (3) @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    dat(8'h12, 10'd0);
    repeat (20) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
